// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter
//  Function : Round-robin arbiter sharing the single register-file write port
//             between the ALU/immediate path (req0) and the load/MAC path
//             (req1). One-entry holding buffer per requester, registered write
//             stage, pending-write mask for hazard stalls, x0-drop counter.
//  Revision : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [ADDR_W-1:0]    req0_rd,
  input  logic [DATA_W-1:0]    req0_data,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [ADDR_W-1:0]    req1_rd,
  input  logic [DATA_W-1:0]    req1_data,
  output logic                 regwrite,
  output logic [ADDR_W-1:0]    rd,
  output logic [DATA_W-1:0]    write_data,
  output logic [2**ADDR_W-1:0] pend_mask,
  output logic [CNT_W-1:0]     drop_count
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  // Holding buffers
  logic              r_full0, r_full1;
  logic [ADDR_W-1:0] r_rd0, r_rd1;
  logic [DATA_W-1:0] r_data0, r_data1;
  // 1 = requester 1 was granted last, so requester 0 wins the next tie
  logic              r_last;

  logic              w_grant0, w_grant1;
  logic              w_acc0, w_acc1;
  logic              w_load0, w_load1;
  logic              w_drop0, w_drop1;
  logic [1:0]        w_drops;
  logic [CNT_W:0]    w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;

  // Grant depends only on buffer occupancy and the last-grant pointer
  assign w_grant0 = r_full0 & (~r_full1 | r_last);
  assign w_grant1 = r_full1 & (~r_full0 | ~r_last);

  // A buffer can accept when empty or when it is being drained this edge
  assign req0_ready = ~r_full0 | w_grant0;
  assign req1_ready = ~r_full1 | w_grant1;

  assign w_acc0  = req0_valid & req0_ready;
  assign w_acc1  = req1_valid & req1_ready;
  assign w_drop0 = w_acc0 & (req0_rd == '0);
  assign w_drop1 = w_acc1 & (req1_rd == '0);
  assign w_load0 = w_acc0 & (req0_rd != '0);
  assign w_load1 = w_acc1 & (req1_rd != '0);

  // Both requesters may drop an x0 write on the same edge, so add up to 2
  assign w_drops    = {1'b0, w_drop0} + {1'b0, w_drop1};
  assign w_cnt_sum  = {1'b0, drop_count} + {{(CNT_W-1){1'b0}}, w_drops};
  assign w_cnt_next = w_cnt_sum[CNT_W] ? c_cnt_max : w_cnt_sum[CNT_W-1:0];

  // Registered write stage feeding the register file, plus round-robin pointer
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite   <= 1'b0;
      rd         <= '0;
      write_data <= '0;
      r_last     <= 1'b1;
    end else begin
      regwrite <= w_grant0 | w_grant1;
      if (w_grant0) begin
        rd         <= r_rd0;
        write_data <= r_data0;
        r_last     <= 1'b0;
      end else if (w_grant1) begin
        rd         <= r_rd1;
        write_data <= r_data1;
        r_last     <= 1'b1;
      end
    end
  end

  // Holding buffers: drain on grant, reload on accept (reload wins same edge)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_full0 <= 1'b0;
      r_rd0   <= '0;
      r_data0 <= '0;
      r_full1 <= 1'b0;
      r_rd1   <= '0;
      r_data1 <= '0;
    end else begin
      if (w_grant0) r_full0 <= 1'b0;
      if (w_load0) begin
        r_full0 <= 1'b1;
        r_rd0   <= req0_rd;
        r_data0 <= req0_data;
      end
      if (w_grant1) r_full1 <= 1'b0;
      if (w_load1) begin
        r_full1 <= 1'b1;
        r_rd1   <= req1_rd;
        r_data1 <= req1_data;
      end
    end
  end

  // Saturating count of accepted writes to x0
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (w_drop0 | w_drop1) begin
      drop_count <= w_cnt_next;
    end
  end

  // Registers with a write buffered or staged, for decode hazard stalls
  always_comb begin
    pend_mask = '0;
    if (r_full0)  pend_mask[r_rd0] = 1'b1;
    if (r_full1)  pend_mask[r_rd1] = 1'b1;
    if (regwrite) pend_mask[rd]    = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Function : Self-checking bench for rf_write_arbiter with a queue-based
//             scoreboard of per-requester pending writes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2**AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [AW-1:0] req0_rd, req1_rd;
  logic [DW-1:0] req0_data, req1_data;
  logic          regwrite;
  logic [AW-1:0] rd;
  logic [DW-1:0] write_data;
  logic [NR-1:0] pend_mask;
  logic [7:0]    drop_count;

  // Second instance with a 2-bit drop counter for saturation
  logic          s_rdy0, s_rdy1, s_we;
  logic [AW-1:0] s_rd;
  logic [DW-1:0] s_data;
  logic [NR-1:0] s_mask;
  logic [1:0]    s_drop;

  always #5 clock = ~clock;

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .regwrite(regwrite), .rd(rd), .write_data(write_data),
    .pend_mask(pend_mask), .drop_count(drop_count)
  );

  rf_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(s_rdy0), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(s_rdy1), .req1_rd(req1_rd), .req1_data(req1_data),
    .regwrite(s_we), .rd(s_rd), .write_data(s_data),
    .pend_mask(s_mask), .drop_count(s_drop)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  // Scoreboard: writes accepted but not yet granted, per requester
  ent_t          q0[$];
  ent_t          q1[$];
  int            n_assert = 0;
  int            n_fail   = 0;
  logic          m_last;
  logic          m_we;
  logic [AW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_mask;
  int            m_drop, m_drop2;
  bit            acc0, acc1;
  int            k0, k1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_last  = 1'b1;
    m_we    = 1'b0;
    m_rd    = '0;
    m_data  = '0;
    m_mask  = '0;
    m_drop  = 0;
    m_drop2 = 0;
  endtask

  task automatic count_drop();
    m_drop  = (m_drop  >= 255) ? 255 : m_drop + 1;
    m_drop2 = (m_drop2 >= 3)   ? 3   : m_drop2 + 1;
  endtask

  task automatic drive0(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req0_valid = v; req0_rd = r; req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req1_valid = v; req1_rd = r; req1_data = d;
  endtask

  // One clock: check ready before the edge, then predict and check outputs #1 after
  task automatic tick();
    bit   g0, g1, rdy0, rdy1;
    ent_t e0, e1, e;
    g0   = (q0.size() > 0) && ((q1.size() == 0) || m_last);
    g1   = (q1.size() > 0) && ((q0.size() == 0) || !m_last);
    rdy0 = (q0.size() == 0) || g0;
    rdy1 = (q1.size() == 0) || g1;
    chk("req0_ready", 64'(req0_ready), 64'(rdy0));
    chk("req1_ready", 64'(req1_ready), 64'(rdy1));
    acc0 = req0_valid && rdy0;
    acc1 = req1_valid && rdy1;
    e0.rd = req0_rd; e0.data = req0_data;
    e1.rd = req1_rd; e1.data = req1_data;
    @(posedge clock);
    #1;
    e = '0;
    if (g0) begin
      e = q0.pop_front();
      m_last = 1'b0;
    end else if (g1) begin
      e = q1.pop_front();
      m_last = 1'b1;
    end
    m_we = g0 || g1;
    if (m_we) begin
      m_rd   = e.rd;
      m_data = e.data;
    end
    if (acc0) begin
      if (e0.rd != '0) q0.push_back(e0);
      else count_drop();
    end
    if (acc1) begin
      if (e1.rd != '0) q1.push_back(e1);
      else count_drop();
    end
    m_mask = '0;
    foreach (q0[i]) m_mask[q0[i].rd] = 1'b1;
    foreach (q1[i]) m_mask[q1[i].rd] = 1'b1;
    if (m_we) m_mask[m_rd] = 1'b1;
    chk("regwrite",    64'(regwrite),   64'(m_we));
    chk("rd",          64'(rd),         64'(m_rd));
    chk("write_data",  64'(write_data), 64'(m_data));
    chk("pend_mask",   64'(pend_mask),  64'(m_mask));
    chk("drop_count",  64'(drop_count), 64'(m_drop));
    chk("drop_count2", 64'(s_drop),     64'(m_drop2));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_regwrite"},   64'(regwrite),   64'(0));
    chk({tag, "_rd"},         64'(rd),         64'(0));
    chk({tag, "_write_data"}, 64'(write_data), 64'(0));
    chk({tag, "_pend_mask"},  64'(pend_mask),  64'(0));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(0));
    chk({tag, "_ready0"},     64'(req0_ready), 64'(1));
    chk({tag, "_ready1"},     64'(req1_ready), 64'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    model_reset();
    #12;
    chk_idle("reset");
    reset = 1'b1;

    // Single uncontested write
    drive0(1'b1, 5'd5, 32'hDEAD_BEEF);
    tick();
    drive0(1'b0, '0, '0);
    repeat (3) tick();

    // Simultaneous first requests; req1 keeps offering through its stall
    drive0(1'b1, 5'd3, 32'h33);
    drive1(1'b1, 5'd4, 32'h44);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b1, 5'd6, 32'h66);
    tick();
    tick();
    drive1(1'b0, '0, '0);
    repeat (3) tick();

    // Both continuously valid: alternating grants
    k0 = 0;
    k1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive0(1'b1, AW'(8 + k0),  32'hA000 + k0);
      drive1(1'b1, AW'(16 + k1), 32'hB000 + k1);
      tick();
      if (acc0) k0++;
      if (acc1) k1++;
    end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    repeat (3) tick();

    // x0 writes: dropped and counted, small counter saturates
    drive1(1'b1, 5'd0, 32'h1234);
    repeat (5) tick();
    drive0(1'b1, 5'd0, 32'h5678);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    tick();
    chk("drop_total", 64'(drop_count), 64'(7));
    chk("drop_sat",   64'(s_drop),     64'(3));

    // Same destination from both requesters
    drive0(1'b1, 5'd7, 32'd1);
    drive1(1'b1, 5'd7, 32'd2);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    repeat (4) tick();

    // Asynchronous reset mid-operation
    drive0(1'b1, 5'd10, 32'hC0);
    drive1(1'b1, 5'd20, 32'hC1);
    repeat (3) tick();
    chk("pre_reset_regwrite", 64'(regwrite), 64'(1));
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk_idle("mid_reset");
    #2;
    reset = 1'b1;

    // Post-reset service, then req0 wins the next tie
    drive1(1'b1, 5'd9, 32'h99);
    tick();
    drive1(1'b0, '0, '0);
    repeat (2) tick();
    drive0(1'b1, 5'd1, 32'h11);
    drive1(1'b1, 5'd2, 32'h22);
    tick();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    tick();
    chk("tie_winner_rd", 64'(rd), 64'(1));
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
